// File: rtl/ws2812_stream_driver_pkg.sv
// Shared types and timing helpers for the WS2812 stream driver.
package ws2812_stream_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Clocks per transmitted bit.
  function automatic int calc_t_bit(input int clk_freq, input int lat_freq);
    return clk_freq / lat_freq;
  endfunction

  // High time of a 0 bit, in clocks.
  function automatic int calc_t0h(input int t_bit);
    return t_bit * 25 / 100;
  endfunction

  // High time of a 1 bit, in clocks.
  function automatic int calc_t1h(input int t_bit);
    return t_bit * 65 / 100;
  endfunction

  // Latch (reset) low time, in clocks.
  function automatic int calc_t_rst(input int reset_us, input int clk_freq);
    return reset_us * (clk_freq / 1000000);
  endfunction

endpackage

// File: rtl/ws2812_stream_driver_if.sv
// Control, status and pixel-stream bundle between a pixel source and the driver.
interface ws2812_stream_driver_if #(
  parameter int BITS_PER_LED = 24,
  parameter int ADDR_W       = 16
);
  logic                    start;
  logic                    cfg_wr;
  logic [ADDR_W-1:0]       cfg_data;
  logic [BITS_PER_LED-1:0] pix_data;
  logic                    pix_valid;
  logic                    pix_ready;
  logic                    busy;
  logic                    frame_done;
  logic                    underrun;

  // Pixel source / controller side.
  modport master (
    output start, cfg_wr, cfg_data, pix_data, pix_valid,
    input  pix_ready, busy, frame_done, underrun
  );

  // Driver side.
  modport slave (
    input  start, cfg_wr, cfg_data, pix_data, pix_valid,
    output pix_ready, busy, frame_done, underrun
  );
endinterface

// File: rtl/ws2812_stream_driver_bit_encoder.sv
// Times one WS2812 bit: high for T1H/T0H clocks, low for the rest of T_BIT.
// bit_start marks clock 0 of a bit; the encoder then runs on its own to the end.
module ws2812_bit_encoder #(
  parameter int T_BIT = 62,
  parameter int T0H   = 15,
  parameter int T1H   = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_val,
  input  logic bit_start,
  output logic level,
  output logic bit_last
);
  localparam int CNT_W = $clog2(T_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] HI_0     = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] HI_1     = CNT_W'(T1H);

  logic [CNT_W-1:0] cnt;
  logic             running;
  logic             active;

  // Level and last-clock flag for the clock currently in progress.
  // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    active   = bit_start | running;
    level    = active & (cnt < (bit_val ? HI_1 : HI_0));
    bit_last = active & (cnt == CNT_LAST);
  end

  // Per-bit clock counter; rests at zero between bits so clock 0 needs no preload.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (active) begin
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        cnt     <= cnt + 1'b1;
        running <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ws2812_stream_driver.sv
// WS2812-family LED driver: pixel stream in, one registered LED data line out.
// A single holding register prefetches the next pixel so LEDs run back to back.
module ws2812_stream_driver
  import ws2812_stream_driver_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int LAT_FREQ     = 800000,
  parameter int BITS_PER_LED = 24,
  parameter int ADDR_W       = 16,
  parameter int RESET_US     = 60,
  parameter bit INVERT       = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  ws2812_stream_driver_if.slave   bus,
  output logic                    dout
);
  localparam int T_BIT = calc_t_bit(CLK_FREQ, LAT_FREQ);
  localparam int T0H   = calc_t0h(T_BIT);
  localparam int T1H   = calc_t1h(T_BIT);
  localparam int T_RST = calc_t_rst(RESET_US, CLK_FREQ);

  localparam int BIT_W = $clog2(BITS_PER_LED);
  localparam int RST_W = (T_RST > 1) ? $clog2(T_RST) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_LED - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(T_RST - 1);

  state_t                  state;
  logic [BITS_PER_LED-1:0] shift_reg;
  logic [BITS_PER_LED-1:0] hold_reg;
  logic                    hold_full;
  logic [BIT_W-1:0]        bit_idx;
  logic [ADDR_W-1:0]       nb_leds;
  logic [ADDR_W-1:0]       sent;
  logic [ADDR_W-1:0]       fetched;
  logic [RST_W-1:0]        latch_cnt;
  logic                    busy;
  logic                    frame_done;
  logic                    underrun;
  logic                    bit_start;

  logic                    level;
  logic                    bit_last;
  logic                    pix_ready;
  logic                    accept;
  logic                    led_end;
  logic [ADDR_W-1:0]       sent_next;
  logic [ADDR_W-1:0]       start_count;

  // NOTE: pix_ready is built from registers only, so it never loops back through pix_valid.
  assign pix_ready   = busy & ~hold_full & (fetched < nb_leds);
  assign accept      = bus.pix_valid & pix_ready;
  assign led_end     = (state == SHIFT) & bit_last & (bit_idx == BIT_LAST);
  assign sent_next   = sent + 1'b1;
  // A cfg_wr in the same cycle as start supplies the count that start uses.
  assign start_count = bus.cfg_wr ? bus.cfg_data : nb_leds;

  assign bus.pix_ready  = pix_ready;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.underrun   = underrun;

  ws2812_bit_encoder #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_encoder (
    .clk       (clk),
    .reset     (reset),
    .bit_val   (shift_reg[BITS_PER_LED-1]),
    .bit_start (bit_start),
    .level     (level),
    .bit_last  (bit_last)
  );

  // Frame FSM with shift/holding registers, LED counters and registered outputs.
  // NOTE: shift_reg and hold_reg carry data only and stay out of reset; state and hold_full gate their use.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      bit_idx    <= '0;
      nb_leds    <= '0;
      sent       <= '0;
      fetched    <= '0;
      latch_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      bit_start  <= 1'b0;
      dout       <= INVERT;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      bit_start  <= 1'b0;
      dout       <= level ^ INVERT;
      if (accept) fetched <= fetched + 1'b1;

      case (state)
        IDLE: begin
          if (bus.cfg_wr) nb_leds <= bus.cfg_data;
          if (bus.start && (start_count != '0)) begin
            state     <= FIRST;
            busy      <= 1'b1;
            sent      <= '0;
            fetched   <= '0;
            hold_full <= 1'b0;
          end
        end

        FIRST: begin
          if (accept) begin
            shift_reg <= bus.pix_data;
            bit_idx   <= '0;
            bit_start <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          // A pixel arriving exactly at the LED boundary bypasses the holding register.
          if (accept && !led_end) begin
            hold_reg  <= bus.pix_data;
            hold_full <= 1'b1;
          end
          if (bit_last) begin
            if (bit_idx == BIT_LAST) begin
              sent    <= sent_next;
              bit_idx <= '0;
              if (sent_next == nb_leds) begin
                state     <= LATCH;
                latch_cnt <= '0;
              end else if (hold_full) begin
                shift_reg <= hold_reg;
                hold_full <= 1'b0;
                bit_start <= 1'b1;
              end else if (accept) begin
                shift_reg <= bus.pix_data;
                bit_start <= 1'b1;
              end else begin
                underrun  <= 1'b1;
                state     <= LATCH;
                latch_cnt <= '0;
              end
            end else begin
              shift_reg <= shift_reg << 1;
              bit_idx   <= bit_idx + 1'b1;
              bit_start <= 1'b1;
            end
          end
        end

        LATCH: begin
          if (latch_cnt == RST_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
